// File: rtl/dc_ipu_array_divider_pipe.sv
// Fully pipelined unsigned restoring array divider: DW stages, one quotient bit per stage, with matched tag delay.
// Optional remainder output is enabled by defining DC_IPU_ARRAY_DIVIDER_PIPE_REMAINDER_EN.
module dc_ipu_array_divider_pipe #(
    parameter int DW = 16,
    parameter int VW = 16,
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          en,
    input  logic          in_valid,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    input  logic [TW-1:0] tag_in,
    output logic          out_valid,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero,
    output logic [TW-1:0] tag_out
);

    localparam int SW = VW + 2;

    // Returns {quotient bit, next partial remainder} for one restoring step (remainder kept at SW bits).
    function automatic logic [SW:0] div_step(input logic [VW:0] rem, input logic dbit,
                                             input logic [VW-1:0] dvs);
        logic [SW-1:0] rp;
        logic [SW-1:0] t;
        rp = {rem, dbit};
        t  = rp - {2'b00, dvs};
        if (t[SW-1] == 1'b0) begin
            div_step = {1'b1, t};
        end else begin
            div_step = {1'b0, rp};
        end
    endfunction

    // Stages 0..DW-2 live in these arrays; stage DW-1 is the output register set.
    logic          valid_r [DW-1];
    logic [VW:0]   rem_r   [DW-1];
    logic [DW-1:0] quo_r   [DW-1];
    logic [DW-1:0] dvd_r   [DW-1];
    logic [VW-1:0] dvs_r   [DW-1];
    logic          zf_r    [DW-1];
    logic [TW-1:0] tag_r   [DW-1];

    logic [SW:0]   step_s  [DW];
    logic [DW-1:0] quo_s   [DW];

    logic          out_valid_r;
    logic [DW-1:0] quotient_r;
    logic          div_by_zero_r;
    logic [TW-1:0] tag_out_r;

    // Per-stage subtract/restore and quotient shift-in.
    always_comb begin
        step_s[0] = div_step({(VW+1){1'b0}}, dividend[DW-1], divisor);
        quo_s[0]  = {{(DW-1){1'b0}}, step_s[0][SW]};
        for (int s = 1; s < DW; s++) begin
            step_s[s] = div_step(rem_r[s-1], dvd_r[s-1][DW-1], dvs_r[s-1]);
            quo_s[s]  = {quo_r[s-1][DW-2:0], step_s[s][SW]};
        end
    end

    // Pipeline stage registers; en low freezes everything.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int s = 0; s < DW - 1; s++) begin
                valid_r[s] <= 1'b0;
                rem_r[s]   <= {(VW+1){1'b0}};
                quo_r[s]   <= {DW{1'b0}};
                dvd_r[s]   <= {DW{1'b0}};
                dvs_r[s]   <= {VW{1'b0}};
                zf_r[s]    <= 1'b0;
                tag_r[s]   <= {TW{1'b0}};
            end
        end else if (en) begin
            valid_r[0] <= in_valid;
            rem_r[0]   <= step_s[0][VW:0];
            quo_r[0]   <= quo_s[0];
            dvd_r[0]   <= {dividend[DW-2:0], 1'b0};
            dvs_r[0]   <= divisor;
            zf_r[0]    <= (divisor == {VW{1'b0}});
            tag_r[0]   <= tag_in;
            for (int s = 1; s < DW - 1; s++) begin
                valid_r[s] <= valid_r[s-1];
                rem_r[s]   <= step_s[s][VW:0];
                quo_r[s]   <= quo_s[s];
                dvd_r[s]   <= {dvd_r[s-1][DW-2:0], 1'b0};
                dvs_r[s]   <= dvs_r[s-1];
                zf_r[s]    <= zf_r[s-1];
                tag_r[s]   <= tag_r[s-1];
            end
        end
    end

    // Final stage: registered outputs, with the divide-by-zero quotient override.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            out_valid_r   <= 1'b0;
            quotient_r    <= {DW{1'b0}};
            div_by_zero_r <= 1'b0;
            tag_out_r     <= {TW{1'b0}};
        end else if (en) begin
            out_valid_r   <= valid_r[DW-2];
            div_by_zero_r <= zf_r[DW-2];
            tag_out_r     <= tag_r[DW-2];
            if (zf_r[DW-2]) begin
                quotient_r <= {DW{1'b1}};
            end else begin
                quotient_r <= quo_s[DW-1];
            end
        end
    end

`ifdef DC_IPU_ARRAY_DIVIDER_PIPE_REMAINDER_EN
    logic [VW-1:0] remainder_r;

    // Final remainder register, forced to zero on divide by zero.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            remainder_r <= {VW{1'b0}};
        end else if (en) begin
            if (zf_r[DW-2]) begin
                remainder_r <= {VW{1'b0}};
            end else begin
                remainder_r <= step_s[DW-1][VW-1:0];
            end
        end
    end

    assign remainder = remainder_r;
`else
    assign remainder = {VW{1'b0}};
`endif

    assign out_valid   = out_valid_r;
    assign quotient    = quotient_r;
    assign div_by_zero = div_by_zero_r;
    assign tag_out     = tag_out_r;

endmodule

// File: tb/tb_dc_ipu_array_divider_pipe.sv
// Directed and scoreboard-checked bench for dc_ipu_array_divider_pipe (default DW=16, VW=16, TW=8).
module tb_dc_ipu_array_divider_pipe;

    localparam int DW = 16;
    localparam int VW = 16;
    localparam int TW = 8;
`ifdef DC_IPU_ARRAY_DIVIDER_PIPE_REMAINDER_EN
    localparam bit REM_ON = 1'b1;
`else
    localparam bit REM_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          nreset;
    logic          en;
    logic          in_valid;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic [TW-1:0] tag_in;
    logic          out_valid;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;
    logic [TW-1:0] tag_out;

    int n_chk  = 0;
    int n_fail = 0;

    logic          h_v [DW];
    logic [DW-1:0] h_q [DW];
    logic [VW-1:0] h_r [DW];
    logic          h_z [DW];
    logic [TW-1:0] h_t [DW];

    dc_ipu_array_divider_pipe #(.DW(DW), .VW(VW), .TW(TW)) dut (
        .clk(clk), .nreset(nreset), .en(en), .in_valid(in_valid),
        .dividend(dividend), .divisor(divisor), .tag_in(tag_in),
        .out_valid(out_valid), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero), .tag_out(tag_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] rem_exp(input logic [VW-1:0] r);
        rem_exp = r & {VW{REM_ON}};
    endfunction

    task automatic clear_model();
        for (int i = 0; i < DW; i++) begin
            h_v[i] = 1'b0; h_q[i] = '0; h_r[i] = '0; h_z[i] = 1'b0; h_t[i] = '0;
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check_eq({name, "_valid"}, out_valid, 0);
        check_eq({name, "_q"}, quotient, 0);
        check_eq({name, "_r"}, remainder, 0);
        check_eq({name, "_dbz"}, div_by_zero, 0);
        check_eq({name, "_tag"}, tag_out, 0);
    endtask

    // One clock with a reference pipeline model: result of an edge-k sample shows after DW en edges.
    task automatic cyc(input logic e, input logic iv, input logic [DW-1:0] a,
                       input logic [VW-1:0] b, input logic [TW-1:0] t);
        en = e; in_valid = iv; dividend = a; divisor = b; tag_in = t;
        @(posedge clk);
        if (e) begin
            for (int i = DW - 1; i > 0; i--) begin
                h_v[i] = h_v[i-1]; h_q[i] = h_q[i-1]; h_r[i] = h_r[i-1];
                h_z[i] = h_z[i-1]; h_t[i] = h_t[i-1];
            end
            h_v[0] = iv;
            h_z[0] = (b == '0);
            h_q[0] = (b == '0) ? {DW{1'b1}} : DW'(a / b);
            h_r[0] = (b == '0) ? {VW{1'b0}} : VW'(a % b);
            h_t[0] = t;
        end
        @(negedge clk);
        check_eq("stream_valid", out_valid, h_v[DW-1]);
        if (h_v[DW-1]) begin
            check_eq("stream_q", quotient, h_q[DW-1]);
            check_eq("stream_r", remainder, rem_exp(h_r[DW-1]));
            check_eq("stream_dbz", div_by_zero, h_z[DW-1]);
            check_eq("stream_tag", tag_out, h_t[DW-1]);
        end
    endtask

    // Single pair into an empty pipe with hand-computed expectations; valid only after edge DW.
    task automatic run_one(input string name, input logic [DW-1:0] a, input logic [VW-1:0] b,
                           input logic [TW-1:0] t, input logic [DW-1:0] eq,
                           input logic [VW-1:0] er, input logic ez);
        en = 1'b1; in_valid = 1'b1; dividend = a; divisor = b; tag_in = t;
        for (int k = 1; k <= DW + 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0; dividend = '0; divisor = '0; tag_in = '0;
            check_eq({name, "_valid"}, out_valid, (k == DW) ? 1 : 0);
            if (k == DW) begin
                check_eq({name, "_q"}, quotient, eq);
                check_eq({name, "_r"}, remainder, rem_exp(er));
                check_eq({name, "_dbz"}, div_by_zero, ez);
                check_eq({name, "_tag"}, tag_out, t);
            end
        end
    endtask

    initial begin
        int cnt;
        int lat;
        bit seen;
        logic e;
        logic iv;
        logic [VW-1:0] b;

        nreset = 1'b0; en = 1'b0; in_valid = 1'b0;
        dividend = '0; divisor = '0; tag_in = '0;
        clear_model();
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        nreset = 1'b1;

        run_one("basic", 16'd100, 16'd7, 8'h5A, 16'd14, 16'd2, 1'b0);
        run_one("max_by_1", 16'hFFFF, 16'd1, 8'h01, 16'hFFFF, 16'd0, 1'b0);
        run_one("zero_by_9", 16'd0, 16'd9, 8'h02, 16'd0, 16'd0, 1'b0);
        run_one("small_by_max", 16'd5, 16'hFFFF, 8'h03, 16'd0, 16'd5, 1'b0);
        run_one("max_by_max", 16'hFFFF, 16'hFFFF, 8'h04, 16'd1, 16'd0, 1'b0);
        run_one("div_zero", 16'd1234, 16'd0, 8'h05, 16'hFFFF, 16'd0, 1'b1);
        run_one("after_dbz", 16'd10, 16'd3, 8'h06, 16'd3, 16'd1, 1'b0);

        // Random stream with bubbles
        clear_model();
        cnt = 0;
        while (cnt < 200) begin
            iv = ($urandom_range(0, 3) != 0);
            b  = ($urandom_range(0, 15) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
            cyc(1'b1, iv, 16'($urandom_range(0, 65535)), b, 8'($urandom_range(0, 255)));
            if (iv) cnt++;
        end
        for (int i = 0; i < DW + 2; i++) cyc(1'b1, 1'b0, '0, '0, '0);

        // Stall with 8 in flight, then a stall while a result is on the outputs
        clear_model();
        lat = 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            e  = !((i >= 15 && i < 20) || (i >= 22 && i < 24));
            iv = (i < 8);
            cyc(e, iv, 16'(1000 + i * 37), 16'(i + 3), 8'(i + 16));
            if (!seen) begin
                lat++;
                if (out_valid) seen = 1'b1;
            end
        end
        check_eq("stall_latency", lat, DW + 5);

        // Reset with 10 results in flight
        clear_model();
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 16'(500 + i), 16'(i + 2), 8'(i + 64));
        #2 nreset = 1'b0;
        #1 check_reset_outputs("midreset");
        @(negedge clk);
        nreset = 1'b1;
        run_one("post_reset", 16'd9, 16'd4, 8'h33, 16'd2, 16'd1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
